// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter that owns a shared 2:1 datapath mux
// between two valid/ready streaming sources, with a registered output stage.
// Each grant is limited to MAX_BURST consecutive beats while the other side
// is requesting, so neither source can starve the other.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in0_valid/data/ready   requester 0 stream (ready is an output)
//   in1_valid/data/ready   requester 1 stream (ready is an output)
//   out_valid/data/ready   registered output stream (ready is an input)
//   sel                    mux select, follows the grant, holds in idle
//   grant                  one-hot grant: 01 = requester 0, 10 = requester 1
module mux2_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [1:0]       grant
);

    typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

    localparam logic [7:0] BurstLen = 8'(MAX_BURST);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             can_load;
    logic             acc0, acc1;
    logic             cur, cur_valid, oth_valid, cur_acc;
    logic             burst_end;
    logic [WIDTH-1:0] mux_data;

    // Ready depends only on the output register state, never on the valids.
    assign can_load  = !out_valid_q || out_ready;
    assign in0_ready = (state_q == StG0) && can_load;
    assign in1_ready = (state_q == StG1) && can_load;
    assign acc0      = in0_valid && in0_ready;
    assign acc1      = in1_valid && in1_ready;

    // Shared 2:1 datapath mux.
    assign mux_data = sel_q ? in1_data : in0_data;

    // View of the granted requester (only meaningful in StG0/StG1).
    assign cur       = (state_q == StG1);
    assign cur_valid = cur ? in1_valid : in0_valid;
    assign oth_valid = cur ? in0_valid : in1_valid;
    assign cur_acc   = acc0 || acc1;
    assign burst_end = (cnt_q + 8'd1) == BurstLen;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in0_valid && in1_valid) begin
                    state_d = last_q ? StG0 : StG1;
                end else if (in0_valid) begin
                    state_d = StG0;
                end else if (in1_valid) begin
                    state_d = StG1;
                end
            end
            StG0, StG1: begin
                if (!cur_valid) begin
                    // Dropping valid forfeits the grant, even during a stall.
                    cnt_d   = 8'd0;
                    last_d  = cur;
                    state_d = oth_valid ? (cur ? StG0 : StG1) : StIdle;
                end else if (cur_acc) begin
                    if (burst_end) begin
                        cnt_d = 8'd0;
                        if (oth_valid) begin
                            state_d = cur ? StG0 : StG1;
                            last_d  = cur;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        if (state_d == StG0) begin
            sel_d = 1'b0;
        end else if (state_d == StG1) begin
            sel_d = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (cur_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            cnt_q       <= 8'd0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign grant     = {state_q == StG1, state_q == StG0};

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0_valid, in1_valid;
    logic [7:0] in0_data, in1_data;
    logic       in0_ready, in1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       sel;
    logic [1:0] grant;

    int tests = 0;
    int fails = 0;
    logic [7:0] sbq[$];

    mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input int base, input int n);
        for (int i = 0; i < n; i++) sbq.push_back(8'(base + i));
    endtask

    // Monitor: every output handshake must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("out_data", {24'd0, out_data}, {24'd0, sbq.pop_front()});
            end
        end
    end

    // Drives both sources cycle by cycle. Cycle c's inputs are applied just
    // after an edge; the negedge of cycle c sees the state after c edges.
    task automatic run_phase(input int n0, input int b0, input int s0,
                             input int n1, input int b1, input int s1,
                             input int st_at, input int st_len,
                             input int gc1, input int gv1, input int gc2, input int gv2,
                             input int oc, input int ov, input int hold_v, input bit nogap);
        int sent0 = 0;
        int sent1 = 0;
        int first = -1;
        int lastc = -1;
        bit a0, a1;
        for (int c = 0; ; c++) begin
            in0_valid = (c >= s0) && (sent0 < n0);
            in0_data  = 8'(b0 + sent0);
            in1_valid = (c >= s1) && (sent1 < n1);
            in1_data  = 8'(b1 + sent1);
            out_ready = !(c >= st_at && c < st_at + st_len);
            @(negedge clk);
            if (c == gc1) chk("grant_a", {30'd0, grant}, gv1);
            if (c == gc2) chk("grant_b", {30'd0, grant}, gv2);
            if (c == oc) begin
                chk("first_valid", {31'd0, out_valid}, 1);
                chk("first_data", {24'd0, out_data}, ov);
            end
            if (!out_ready && out_valid) begin
                chk("stall_ready", {30'd0, in0_ready, in1_ready}, 0);
                chk("stall_hold", {24'd0, out_data}, hold_v);
            end
            a0 = in0_valid && in0_ready;
            a1 = in1_valid && in1_ready;
            if (a0 || a1) begin
                if (first < 0) first = c;
                lastc = c;
            end
            @(posedge clk);
            #1;
            if (a0) sent0++;
            if (a1) sent1++;
            if (sent0 == n0 && sent1 == n1 && sbq.size() == 0) break;
            if (c >= 80) begin
                chk("phase_timeout", c, 0);
                break;
            end
        end
        if (nogap) chk("no_gap", lastc - first, n0 + n1 - 1);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_data  = 8'hB0;
        out_ready = 1'b1;

        // Reset with both requesters active.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_grant", {30'd0, grant}, 0);
            chk("rst_sel", {31'd0, sel}, 0);
            chk("rst_out_valid", {31'd0, out_valid}, 0);
            chk("rst_out_data", {24'd0, out_data}, 0);
            chk("rst_readies", {30'd0, in0_ready, in1_ready}, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both requesting: A0-3 B0-3 A4-7 B4-7, contiguous; first tie goes to in0.
        push_seq(8'hA0, 4); push_seq(8'hB0, 4); push_seq(8'hA4, 4); push_seq(8'hB4, 4);
        run_phase(8, 8'hA0, 0, 8, 8'hB0, 0, 99, 0, 1, 1, 5, 2, 2, 8'hA0, 0, 1'b1);

        // Single requester past the burst limit: grant stays on in0.
        push_seq(8'h10, 6);
        run_phase(6, 8'h10, 0, 0, 0, 99, 99, 0, 1, 1, 6, 1, 2, 8'h10, 0, 1'b1);

        // Tie after in0 was last served goes to in1; in1 releases early after 3 beats.
        push_seq(8'hD0, 3); push_seq(8'hC0, 2);
        run_phase(2, 8'hC0, 0, 3, 8'hD0, 0, 99, 0, 1, 2, 5, 1, 2, 8'hD0, 0, 1'b0);

        // Early release: in0 drops after 2 beats with in1 waiting.
        push_seq(8'hE0, 2); push_seq(8'hF0, 2);
        run_phase(2, 8'hE0, 0, 2, 8'hF0, 1, 99, 0, 3, 1, 4, 2, 3, 8'hE1, 0, 1'b0);

        // Backpressure mid-burst: 5 stalled cycles holding 0x41, burst count preserved.
        push_seq(8'h40, 4); push_seq(8'h50, 4); push_seq(8'h44, 2); push_seq(8'h54, 2);
        run_phase(6, 8'h40, 0, 6, 8'h50, 0, 3, 5, 1, 1, 10, 2, 2, 8'h40, 8'h41, 1'b0);

        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-requester round-robin arbiter that shares one 2:1 datapath mux (`mux2_1`) between two streaming sources. It owns the mux select, applies valid/ready handshakes on both inputs and the output, and limits each grant to a bounded burst so neither source can starve the other. The output is registered, so the shared path is one pipeline stage deep.

## Interface
- `WIDTH`, 8: data width of each input and of the output.
- `MAX_BURST`, 4: maximum consecutive beats accepted from one requester while the other requests; legal range is 1..255.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in0_valid`  in  1  requester 0 has a beat.
- `in0_data`  in  WIDTH  requester 0 data.
- `in0_ready`  out  1  beat from requester 0 is accepted this cycle.
- `in1_valid`  in  1  requester 1 has a beat.
- `in1_data`  in  WIDTH  requester 1 data.
- `in1_ready`  out  1  beat from requester 1 is accepted this cycle.
- `out_valid`  out  1  registered output beat valid.
- `out_data`  out  WIDTH  registered output data.
- `out_ready`  in  1  downstream accepts the output beat.
- `sel`  out  1  mux select: 0 selects in0, 1 selects in1. Equals the current grant; holds its last value in IDLE.
- `grant`  out  2  one-hot grant: `01` is G0, `10` is G1, `00` is IDLE.

## Operation
- **FSM states:** IDLE, G0, G1. State is registered.
- **Priority pointer:** `last` records the most recently granted requester. Reset value is 1, so requester 0 wins the first tie.
- **Leaving IDLE:**
  - Only requester i valid: go to Gi.
  - Both valid: go to the requester that is not `last`.
  - Neither valid: stay in IDLE.
- **Acceptance:** `can_load = !out_valid || out_ready`. In Gi, `ini_ready = can_load`; the other requester's ready is 0. No ready is asserted in IDLE.
- **Beat counter:** `cnt` is 8 bits. It increments on each accepted beat in Gi.
- **Transitions out of Gi:**
  - Accept with `cnt+1 == MAX_BURST` and the other requester valid: go to G(other), `cnt` = 0, `last` = i. There is no bubble.
  - Accept with `cnt+1 == MAX_BURST` and the other requester idle: stay in Gi, `cnt` = 0.
  - `ini_valid` low: go to G(other) if it is valid, otherwise IDLE. `cnt` = 0 and `last` = i.
- **Source rules:** a requester must hold valid and data stable until accepted. A requester that drops valid forfeits its grant.
- **Output register:**
  - On acceptance, `out_data` loads the selected input and `out_valid` is set to 1.
  - If there is no acceptance and `out_ready` is high, `out_valid` is cleared to 0.
  - If `out_ready` is low, the output register holds.
- **Reset state** (rst_n low at a clock edge): IDLE, `grant` = 00, `sel` = 0, `last` = 1, `cnt` = 0, `out_valid` = 0, `out_data` = 0, both readies 0. A reset mid-burst drops any unaccepted beat and any held output beat.

## Timing
- A request arriving in IDLE is granted at the next edge and accepted in the cycle after that. The first output appears 2 cycles after `inN_valid` rises.
- In Gi, input-to-output latency is 1 cycle.
- Throughput in steady state is 1 beat per cycle while `out_ready` stays high, including across burst-limit switches.
- `inN_ready` depends combinationally on `out_ready` and `out_valid`; there is no combinational path from `inN_valid` to `inN_ready`.
- When a grant is released because valid dropped, at least one idle cycle occurs before the next acceptance.
- `out_ready` low with `out_valid` high stalls the block: nothing is accepted, and `cnt` and the FSM hold (transitions triggered by valid dropping still apply).

## Test plan
- **Reset:** hold rst_n low for 3 cycles while driving both valids -> all outputs at their reset values. After release, the first grant is `01`.
- **Single requester:** `in0_valid`=1 continuously with data 0x10, 0x11, … and `out_ready`=1 -> `grant`=01 from cycle 1, `out_data` 0x10 at cycle 2, then one beat per cycle. Grant never switches.
- **Both requesting, MAX_BURST=4:** in0 sends 0xA0.., in1 sends 0xB0.. -> output sequence A0 A1 A2 A3 B0 B1 B2 B3 A4 … with no gaps. `sel` toggles every 4 beats.
- **Backpressure:** `out_ready`=0 for 5 cycles mid-burst -> `out_data` holds, both readies are 0, and `cnt` is unchanged. No beats are lost or duplicated after release.
- **Early release:** in0 drops valid after 2 beats while in1 is valid -> the next edge gives `grant`=10, and B0 follows one bubble cycle later.
- **Tie from IDLE after in1 was last served:** both valid -> `grant`=01. Both valid after in0 was last served -> `grant`=10.
